// File: rtl/mem_hs_if.sv
// Request/response bus of the handshake memory core.
// The master issues one request per valid cycle; the slave answers one
// cycle later with ready, plus read data and the uninitialised-read flag.
interface mem_hs_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  valid;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;
    logic                  rd_uninit;

    modport master (
        output valid, wr_rd, addr, wdata,
        input  rdata, ready, rd_uninit
    );

    modport slave (
        input  valid, wr_rd, addr, wdata,
        output rdata, ready, rd_uninit
    );
endinterface

// File: rtl/mem_hs_core.sv
// Single-ported word memory with a fixed one-cycle response handshake.
// Every valid cycle is accepted; ready follows valid by one cycle. A
// per-word written flag makes reads of never-written words return zero
// and raise rd_uninit, so the array itself never needs clearing.
module mem_hs_core #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        res,
    mem_hs_if.slave     bus,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;
    logic [WIDTH-1:0] rdata_q;
    logic             vld_q;
    logic             uninit_q;

    logic wr_req;
    logic rd_req;

    assign wr_req = bus.valid &  bus.wr_rd;
    assign rd_req = bus.valid & ~bus.wr_rd;

    assign bus.ready     = vld_q;
    assign bus.rdata     = rdata_q;
    assign bus.rd_uninit = uninit_q;

    // Storage array: no reset so it maps onto RAM. A write landing while
    // res is low reaches the array but is never observable, because the
    // written flags are held clear throughout reset.
    always_ff @(posedge clk) begin
        if (wr_req)
            mem[bus.addr] <= bus.wdata;
    end

    // Written flags: cleared by reset, set by each accepted write.
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            written <= '0;
        else if (wr_req)
            written[bus.addr] <= 1'b1;
    end

    // Response stage: ready is valid delayed by one cycle; reads load
    // rdata (zero for unwritten words), writes leave it untouched.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            vld_q    <= 1'b0;
            uninit_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            vld_q    <= bus.valid;
            uninit_q <= rd_req & ~written[bus.addr];
            if (rd_req)
                rdata_q <= written[bus.addr] ? mem[bus.addr] : '0;
        end
    end

    // Saturating request counters.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_req && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
            if (rd_req && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_hs_core.sv
// Self-checking bench for mem_hs_core: stimulus pushes expected
// responses into a queue at the accepting edge, a negedge monitor pops
// and compares whenever ready is presented.
module tb_mem_hs_core;
    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             uninit;
    } rsp_t;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    mem_hs_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    mem_hs_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .res   (res),
        .bus   (bus.slave),
        .wr_cnt(wr_cnt),
        .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays and integer counts.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_wr  [DEPTH];
    logic [WIDTH-1:0] m_rdata;
    int               m_wcnt;
    int               m_rcnt;
    rsp_t             expq [$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
        m_rdata = '0;
        m_wcnt  = 0;
        m_rcnt  = 0;
        expq.delete();
    endtask

    // Drive one request, wait for its edge, then record what it should do.
    task automatic issue(input bit wr, input int a, input logic [WIDTH-1:0] d);
        rsp_t r;
        bus.valid = 1'b1;
        bus.wr_rd = wr;
        bus.addr  = AW'(a);
        bus.wdata = wr ? d : 'x;
        @(posedge clk);
        if (res) begin
            if (wr) begin
                m_mem[a] = d;
                m_wr[a]  = 1;
                m_wcnt++;
            end else begin
                m_rdata = m_wr[a] ? m_mem[a] : '0;
                m_rcnt++;
            end
            r.data   = m_rdata;
            r.uninit = !wr && !m_wr[a];
            expq.push_back(r);
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        bus.wr_rd = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, ready must match a pending expectation.
    always @(negedge clk) begin
        rsp_t r;
        chk("ready", 32'(bus.ready), 32'(expq.size() > 0));
        if (bus.ready && expq.size() > 0) begin
            r = expq.pop_front();
            chk("rdata", 32'(bus.rdata), 32'(r.data));
            chk("rd_uninit", 32'(bus.rd_uninit), 32'(r.uninit));
            chk("rdata_known", 32'($isunknown(bus.rdata)), 32'(0));
        end else begin
            chk("uninit_idle", 32'(bus.rd_uninit), 32'(0));
            chk("rdata_hold", 32'(bus.rdata), 32'(m_rdata));
        end
        chk("wr_cnt", 32'(wr_cnt), 32'(sat16(m_wcnt)));
        chk("rd_cnt", 32'(rd_cnt), 32'(sat16(m_rcnt)));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        bus.valid = 1'b1;
        bus.wr_rd = 1'b1;
        bus.addr  = '0;
        bus.wdata = 16'h1234;
        // Request held during reset must be dropped.
        repeat (3) @(posedge clk);
        #1;
        idle(0);
        res = 1'b1;

        // Read of never-written top word right after reset.
        issue(0, 63, '0);
        idle(2);
        chk("dir_rd_cnt_after_uninit", 32'(rd_cnt), 32'd1);
        chk("dir_wr_cnt_after_uninit", 32'(wr_cnt), 32'd0);

        // Write then immediate read of the same word.
        issue(1, 5, 16'hA5A5);
        issue(0, 5, '0);
        idle(1);
        chk("dir_rdata_a5a5", 32'(bus.rdata), 32'h0000A5A5);

        // Eight back-to-back alternating write/read on addr 0..3.
        for (int i = 0; i < 4; i++) begin
            issue(1, i, 16'(16'h1000 + i));
            issue(0, i, '0);
        end
        idle(2);
        chk("dir_wr_cnt_burst", 32'(wr_cnt), 32'd5);
        chk("dir_rd_cnt_burst", 32'(rd_cnt), 32'd6);

        // Write addr 7, reset while its response is on the bus.
        issue(1, 7, 16'hBEEF);
        #1;
        res = 1'b0;
        model_reset();
        #1;
        chk("dir_ready_async_drop", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        issue(1, 7, 16'hDEAD);   // dropped: reset still active
        idle(1);
        res = 1'b1;
        issue(0, 7, '0);
        idle(1);
        chk("dir_uninit_after_reset", 32'(bus.rdata), 32'd0);

        // Randomized traffic, biased toward a few words to mix hits and misses.
        for (int i = 0; i < 800; i++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                            : int'($urandom_range(0, 11));
            if ($urandom_range(0, 4) == 0)
                idle($urandom_range(1, 2));
            else
                issue($urandom_range(0, 1), a, 16'($urandom));
        end
        idle(2);

        // Drive the read counter past saturation.
        for (int i = 0; i < 65540; i++)
            issue(0, i % DEPTH, '0);
        idle(2);
        chk("dir_rd_cnt_saturated", 32'(rd_cnt), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
